// File: rtl/servo_pkg.sv
// servo_pkg: default servo timing constants and the width clamp shared by the servo drivers
package servo_pkg;
  localparam int DEF_PERIOD = 20000;
  localparam int DEF_MIN_W = 500;
  localparam int DEF_MAX_W = 2500;
  localparam int DEF_RST_W = 1500;
  function automatic int unsigned clamp_w(input int unsigned w, input int unsigned mn, input int unsigned mx);
    return w == 0 ? 32'd0 : w < mn ? mn : w > mx ? mx : w;
  endfunction
endpackage

// File: rtl/servo_slew.sv
// servo_slew: next active width for one channel at a frame boundary.
// With SERVO_SLEW_EN defined the width moves toward the target by at most SLEW_STEP per frame.
module servo_slew #(
  parameter int CNT_W = 16
`ifdef SERVO_SLEW_EN
  , parameter int SLEW_STEP = 100
`endif
) (
  input  logic [CNT_W-1:0] tgt,
  input  logic [CNT_W-1:0] act,
  input  logic             boundary,
  output logic [CNT_W-1:0] nxt
);
`ifdef SERVO_SLEW_EN
  localparam logic signed [CNT_W:0] STEP = (CNT_W+1)'(SLEW_STEP);
  logic signed [CNT_W:0] diff;
  assign diff = $signed({1'b0, tgt}) - $signed({1'b0, act});
  // switching off, or waking from off, bypasses the slew limit
  assign nxt = !boundary ? act :
               (tgt == '0 || act == '0) ? tgt :
               diff > STEP ? act + CNT_W'(SLEW_STEP) :
               diff < -STEP ? act - CNT_W'(SLEW_STEP) : tgt;
`else
  assign nxt = boundary ? tgt : act;
`endif
endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: CH servo pulse outputs on one shared frame counter; widths apply at frame boundaries.
// Define SERVO_SLEW_EN to slew-limit width changes per frame.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int CH = 4,
  parameter int CNT_W = 16,
  parameter int PERIOD = DEF_PERIOD,
  parameter int MIN_W = DEF_MIN_W,
  parameter int MAX_W = DEF_MAX_W,
  parameter int RST_W = DEF_RST_W,
  parameter int SLEW_STEP = 100,
  localparam int CH_W = CH > 1 ? $clog2(CH) : 1
) (
  input  logic             clk_1m,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_width,
  output logic             wr_err,
  output logic             frame_tick,
  output logic [CH-1:0]    pwm_out
);
  logic [CNT_W-1:0] cnt, wr_w;
  logic [CNT_W-1:0] tgt [CH];
  logic [CNT_W-1:0] act [CH];
  logic [CNT_W-1:0] nxt [CH];
  logic boundary;
  if (MAX_W >= PERIOD || SLEW_STEP < 1 || ((PERIOD - 1) >> CNT_W) != 0) begin : g_bad_cfg
    $error("servo_pwm_multi: invalid configuration");
  end
  assign boundary = cnt == CNT_W'(PERIOD - 1);
  assign wr_w = CNT_W'(clamp_w(32'(wr_width), MIN_W, MAX_W));
  for (genvar i = 0; i < CH; i++) begin : g_ch
    servo_slew #(
      .CNT_W(CNT_W)
`ifdef SERVO_SLEW_EN
      , .SLEW_STEP(SLEW_STEP)
`endif
    ) u_slew (
      .tgt(tgt[i]),
      .act(act[i]),
      .boundary(boundary),
      .nxt(nxt[i])
    );
  end
  // act <= MAX_W < PERIOD keeps the output low at the boundary cycle, so updates never cut a pulse
  always_ff @(posedge clk_1m or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      frame_tick <= 1'b0;
      wr_err <= 1'b0;
      pwm_out <= '0;
      for (int i = 0; i < CH; i++) begin
        tgt[i] <= CNT_W'(RST_W);
        act[i] <= CNT_W'(RST_W);
      end
    end else begin
      cnt <= boundary ? '0 : cnt + 1'b1;
      frame_tick <= cnt == '0;
      wr_err <= wr_valid && {1'b0, wr_ch} >= (CH_W+1)'(CH);
      for (int i = 0; i < CH; i++) begin
        if (wr_valid && wr_ch == CH_W'(i)) tgt[i] <= wr_w;
        act[i] <= nxt[i];
        pwm_out[i] <= cnt < act[i];
      end
    end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: scoreboard bench; expected per-frame widths are queued as frames start and checked when they end.
module tb_servo_pwm_multi;
  localparam int CH = 4, P = 2000, MINW = 50, MAXW = 250, RSTW = 150, STEP = 10;
  typedef struct { int w[CH]; } frame_t;
  logic clk_1m = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, wr_valid2 = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [15:0] wr_width = '0;
  logic wr_err, frame_tick, wr_err2, frame_tick2;
  logic [CH-1:0] pwm_out;
  logic [2:0] pwm_out2;
  int n_chk = 0, n_fail = 0;
  frame_t sb[$];
  int m_tgt[CH], m_act[CH];
  int pend_ch = -1, pend_w = 0, pos = 0;
  servo_pwm_multi #(.CH(CH), .CNT_W(16), .PERIOD(P), .MIN_W(MINW), .MAX_W(MAXW), .RST_W(RSTW), .SLEW_STEP(STEP)) dut (
    .clk_1m(clk_1m), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_width(wr_width),
    .wr_err(wr_err), .frame_tick(frame_tick), .pwm_out(pwm_out)
  );
  servo_pwm_multi #(.CH(3), .CNT_W(16), .PERIOD(P), .MIN_W(MINW), .MAX_W(MAXW), .RST_W(RSTW), .SLEW_STEP(STEP)) dut3 (
    .clk_1m(clk_1m), .rst_n(rst_n), .wr_valid(wr_valid2), .wr_ch(wr_ch), .wr_width(wr_width),
    .wr_err(wr_err2), .frame_tick(frame_tick2), .pwm_out(pwm_out2)
  );
  always #5 clk_1m = ~clk_1m;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int clampm(input int w);
    return w == 0 ? 0 : w < MINW ? MINW : w > MAXW ? MAXW : w;
  endfunction
  function automatic int nxt_act(input int a, input int t);
    if (t == 0 || a == 0) return t;
`ifdef SERVO_SLEW_EN
    if (t - a > STEP) return a + STEP;
    if (a - t > STEP) return a - STEP;
`endif
    return t;
  endfunction
  task automatic wait_tick();
    bit got = 1'b0;
    for (int k = 0; k < 3 * P && !got; k++) begin
      @(negedge clk_1m);
      got = frame_tick;
    end
    chk("tick_wait", int'(got), 1);
  endtask
  task automatic start_frame();
    frame_t f;
    wait_tick();
    for (int i = 0; i < CH; i++) begin
      m_act[i] = nxt_act(m_act[i], m_tgt[i]);
      f.w[i] = m_act[i];
    end
    if (pend_ch >= 0) begin
      m_tgt[pend_ch] = clampm(pend_w);
      pend_ch = -1;
    end
    sb.push_back(f);
    pos = 1;
  endtask
  task automatic write_at(input int ch, input int w, input int c);
    repeat (c - pos) @(negedge clk_1m);
    wr_valid = 1'b1;
    wr_ch = 2'(ch);
    wr_width = 16'(w);
    @(negedge clk_1m);
    wr_valid = 1'b0;
    pos = c + 1;
    chk("wr_err_valid", int'(wr_err), 0);
    if (c == P - 1) begin
      pend_ch = ch;
      pend_w = w;
    end else m_tgt[ch] = clampm(w);
  endtask
  task automatic err_at(input int c);
    repeat (c - pos) @(negedge clk_1m);
    wr_valid2 = 1'b1;
    wr_ch = 2'd3;
    wr_width = 16'd100;
    @(negedge clk_1m);
    wr_valid2 = 1'b0;
    chk("wr_err_pulse", int'(wr_err2), 1);
    @(negedge clk_1m);
    chk("wr_err_drop", int'(wr_err2), 0);
    pos = c + 2;
  endtask
  int hi[CH], first[CH], len = 0;
  bit started = 1'b0;
  logic [CH-1:0] prev = '0;
  frame_t mf;
  always @(negedge clk_1m) begin
    if (!rst_n) begin
      started = 1'b0;
      prev = '0;
    end else begin
      if (frame_tick) begin
        chk("pre_tick_low", int'(prev), 0);
        if (started) begin
          chk("frame_len", len, P);
          if (sb.size() == 0) chk("sb_empty", 0, 1);
          else begin
            mf = sb.pop_front();
            for (int i = 0; i < CH; i++) begin
              chk($sformatf("width_ch%0d", i), hi[i], mf.w[i]);
              chk($sformatf("rise_ch%0d", i), first[i], int'(mf.w[i] > 0));
            end
          end
        end
        started = 1'b1;
        len = 0;
        for (int i = 0; i < CH; i++) begin
          hi[i] = 0;
          first[i] = int'(pwm_out[i]);
        end
      end
      if (started) begin
        len++;
        for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
      end
      prev = pwm_out;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int mask;
    for (int i = 0; i < CH; i++) begin
      m_tgt[i] = RSTW;
      m_act[i] = RSTW;
    end
    repeat (3) @(negedge clk_1m);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_err", int'(wr_err), 0);
    rst_n = 1'b1;
    start_frame();
    write_at(2, 100, 500);
    start_frame();
    write_at(0, 10, 100);
    err_at(150);
    write_at(3, 300, 300);
    start_frame();
    write_at(2, 0, 50);
    start_frame();
    write_at(1, 80, P - 1);
    start_frame();
    write_at(0, 90, 200);
    write_at(0, 120, 400);
    start_frame();
    write_at(0, 170, 10);
    repeat (5) start_frame();
    write_at(0, 0, 10);
    start_frame();
    write_at(0, 100, 10);
    start_frame();
    start_frame();
    repeat (70 - pos) @(negedge clk_1m);
    mask = 0;
    for (int i = 0; i < CH; i++) if (m_act[i] > 69) mask |= 1 << i;
    chk("pre_rst_pwm", int'(pwm_out), mask);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_tick", int'(frame_tick), 0);
    sb.delete();
    for (int i = 0; i < CH; i++) begin
      m_tgt[i] = RSTW;
      m_act[i] = RSTW;
    end
    pend_ch = -1;
    repeat (3) @(negedge clk_1m);
    rst_n = 1'b1;
    start_frame();
    start_frame();
    wait_tick();
    @(negedge clk_1m);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
